uart_tx_arbiter: RTL and testbench

//  Shares the single UART byte transmitter between NUM_REQ message sources, e.g. stats dump, RX echo and debug.

---
 rtl/uart_arb_pkg.sv | 16 +
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_t;

  // Width of a requester index; a single requester still gets a 1-bit field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  int idx;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    winner  = '0;
    any_req = |req;
    idx     = 0;
    // Scan from the farthest offset down so the closest request to ptr wins last.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (req[idx]) winner = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter in front of the UART byte serializer.
// Optional stall timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 3,
  parameter  int DATA_W      = UART_BYTE_W,
  parameter  int TIMEOUT_CYC = 4096,
  localparam int IDX_W       = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_pulse
`endif
);

  if (NUM_REQ < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ and TIMEOUT_CYC must be >= 1");
  end

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] next_ptr;
  logic             any_req;
  logic             g_last;
  logic             end_msg;
  logic             stall_abort;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Zero-latency passthrough of the granted lane while locked.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    g_last    = 1'b0;
    if (state == ARB_LOCK) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id == IDX_W'(i)) begin
          tx_valid     = req_valid[i];
          tx_data      = req_data[i*DATA_W +: DATA_W];
          req_ready[i] = tx_ready;
          g_last       = req_last[i];
        end
      end
    end
  end

  assign busy     = (state == ARB_LOCK);
  assign end_msg  = tx_valid & tx_ready & g_last;
  assign next_ptr = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    if (rst) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_id <= winner;
            state    <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (end_msg || stall_abort) begin
            state <= ARB_IDLE;
            ptr   <= next_ptr;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] stall_cnt;

  // Abort on the cycle that would be the TIMEOUT_CYC-th consecutive stall.
  assign stall_abort = (state == ARB_LOCK) && !tx_valid &&
                       (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= stall_abort;
      if (state != ARB_LOCK || tx_valid || stall_abort) stall_cnt <= '0;
      else                                               stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_abort = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: message-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N = 3;
  localparam int W = 8;

  typedef struct {
    logic [7:0] data;
    bit         last;
    int         src;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic         tx_valid;
  logic [W-1:0] tx_data;
  logic         tx_ready;
  logic [1:0]   grant_id;
  logic         busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic         timeout_pulse;
`endif

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  beat_t stage_q[N][$];
  beat_t drv_q[N][$];
  beat_t sb[$];
  int    gap[N];
  int    force_gap[N];
  bit    rand_gaps  = 1'b0;
  bit    rand_ready = 1'b0;
  bit    mon_en     = 1'b0;
  int    since_rel  = 0;
  int    model_ptr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_msg(input int src, input int len, input bit rnd, input logic [7:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = rnd ? 8'($urandom) : base + 8'(k);
      b.last = (k == len - 1);
      b.src  = src;
      stage_q[src].push_back(b);
    end
  endtask

  task automatic drive();
    logic [N-1:0]   v = '0;
    logic [N-1:0]   l = '0;
    logic [N*W-1:0] d = '0;
    for (int i = 0; i < N; i++) begin
      if (drv_q[i].size() > 0 && gap[i] == 0) begin
        v[i]         = 1'b1;
        l[i]         = drv_q[i][0].last;
        d[i*W +: W]  = drv_q[i][0].data;
      end else begin
        l[i]         = 1'($urandom_range(1));
        d[i*W +: W]  = 8'($urandom);
      end
    end
    req_valid = v;
    req_last  = l;
    req_data  = d;
  endtask

  // Reference model: all staged messages are pending at once, so they leave
  // whole, in round-robin order starting from the model's pointer.
  task automatic commit();
    int    p = model_ptr;
    int    found;
    beat_t b;
    do begin
      found = -1;
      for (int off = 0; off < N; off++)
        if (found < 0 && stage_q[(p + off) % N].size() > 0) found = (p + off) % N;
      if (found >= 0) begin
        do begin
          b = stage_q[found].pop_front();
          sb.push_back(b);
          drv_q[found].push_back(b);
        end while (!b.last);
        p = (found + 1) % N;
      end
    end while (found >= 0);
    model_ptr = p;
    drive();
  endtask

  task automatic step();
    logic [N-1:0] hs;
    beat_t        b;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] === 1'b1 && !rst) begin
        b = drv_q[i].pop_front();
        if (!b.last) begin
          if (force_gap[i] > 0) begin
            gap[i]       = force_gap[i];
            force_gap[i] = 0;
          end else if (rand_gaps && $urandom_range(3) == 0) begin
            gap[i] = $urandom_range(6, 1);
          end
        end
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
    end
    if (rand_ready) tx_ready = ($urandom_range(9) < 7);
    drive();
  endtask

  function automatic bit pending();
    pending = (sb.size() > 0);
    for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) pending = 1'b1;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    check("drain_bytes_left", 32'(sb.size()), 0);
    step();
    step();
  endtask

  // One reset edge; outputs checked while requesters still present data.
  task automatic do_reset();
    mon_en = 1'b0;
    rst    = 1'b1;
    step();
    check("rst_tx_valid",  32'(tx_valid),  0);
    check("rst_busy",      32'(busy),      0);
    check("rst_grant_id",  32'(grant_id),  0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_tx_data",   32'(tx_data),   0);
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      stage_q[i].delete();
      gap[i]       = 0;
      force_gap[i] = 0;
    end
    sb.delete();
    model_ptr = 0;
    since_rel = 0;
    drive();
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    beat_t h;
    if (mon_en) begin
      if (since_rel == 1) begin
        check("bubble_busy", 32'(busy), 0);
        since_rel = 2;
      end else if (since_rel == 2) begin
        if (sb.size() > 0) check("rearb_busy", 32'(busy), 1);
        since_rel = 0;
      end
      if (!busy) begin
        check("idle_tx_valid",  32'(tx_valid),  0);
        check("idle_req_ready", 32'(req_ready), 0);
        check("idle_tx_data",   32'(tx_data),   0);
      end else if (sb.size() == 0) begin
        check("busy_without_msg", 32'(busy), 0);
      end else begin
        h = sb[0];
        check("grant_id",  32'(grant_id), 32'(h.src));
        check("tx_valid",  32'(tx_valid), 32'(req_valid[h.src]));
        check("req_ready", 32'(req_ready), tx_ready ? (32'(1) << h.src) : 32'(0));
        if (tx_valid) begin
          check("tx_data", 32'(tx_data), 32'(h.data));
          if (tx_ready) begin
            void'(sb.pop_front());
            if (h.last) since_rel = 1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    tx_ready  = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      gap[i]       = 0;
      force_gap[i] = 0;
    end
    do_reset();

    // Single message from requester 1, one-cycle grant latency.
    add_msg(1, 3, 1'b0, 8'h41);
    commit();
    #1;
    check("t1_idle_no_tx", 32'(tx_valid), 0);
    step();
    check("t1_grant",    32'(grant_id), 1);
    check("t1_tx_valid", 32'(tx_valid), 1);
    check("t1_first",    32'(tx_data),  32'h41);
    drain(50);

    // Contention from reset: expected order 0,1,2,0,1,2.
    do_reset();
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < N; s++) add_msg(s, $urandom_range(4, 1), 1'b1, 8'h00);
    commit();
    drain(200);

    // Backpressure: tx_ready low for 5 cycles after two bytes.
    add_msg(0, 6, 1'b1, 8'h00);
    commit();
    n = 0;
    while (sb.size() > 4 && n < 50) begin
      step();
      n++;
    end
    tx_ready = 1'b0;
    repeat (5) step();
    tx_ready = 1'b1;
    drain(50);

    // Stall: requester 2 drops valid 10 cycles while requester 0 waits.
    do_reset();
    add_msg(1, 1, 1'b0, 8'h11);
    commit();
    drain(20);
    add_msg(2, 3, 1'b0, 8'h21);
    add_msg(0, 2, 1'b0, 8'h01);
    force_gap[2] = 10;
    commit();
    drain(100);

    // Randomized traffic, backpressure and mid-message gaps.
    rand_ready = 1'b1;
    rand_gaps  = 1'b1;
    repeat (25) begin
      for (int s = 0; s < N; s++)
        repeat ($urandom_range(3)) add_msg(s, $urandom_range(5, 1), 1'b1, 8'h00);
      commit();
      drain(1000);
    end
    rand_ready = 1'b0;
    rand_gaps  = 1'b0;
    tx_ready   = 1'b1;

    // Reset in LOCK after byte 2 of 4; pointer restarts at 0.
    add_msg(0, 4, 1'b1, 8'h00);
    commit();
    n = 0;
    while (sb.size() > 2 && n < 50) begin
      step();
      n++;
    end
    check("t5_two_sent", 32'(sb.size()), 2);
    do_reset();
    add_msg(1, 2, 1'b0, 8'h51);
    add_msg(2, 2, 1'b0, 8'h61);
    commit();
    step();
    check("t5_grant_after_reset", 32'(grant_id), 1);
    drain(50);

`ifdef UART_ARB_TIMEOUT_EN
    // Requester 0 stalls past the limit while requester 1 waits.
    do_reset();
    add_msg(0, 2, 1'b0, 8'hA0);
    add_msg(1, 1, 1'b0, 8'hB0);
    force_gap[0] = 30;
    commit();
    mon_en = 1'b0;
    n = 0;
    while (drv_q[0].size() == 2 && n < 20) begin
      step();
      n++;
    end
    n = 0;
    while (timeout_pulse !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("to_stall_cycles", 32'(n), 16);
    check("to_idle", 32'(busy), 0);
    step();
    check("to_pulse_width", 32'(timeout_pulse), 0);
    check("to_grant", 32'(grant_id), 1);
    check("to_data",  32'(tx_data), 32'hB0);
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
